// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared framebuffer geometry, bus widths and read-owner type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W     = 200;
    localparam int FB_H     = 600;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int PIX_W    = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN_RD = 2'd1,
        DRAW_RD = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/fb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fb_starve_ctr
//  Description : Saturating count of consecutive refused draw-request cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_starve_ctr #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_draw_req,
    input  logic i_draw_gnt,
    output logic o_starved
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_draw_req || i_draw_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starved = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Single-port framebuffer arbiter, scan-out priority with
//                bounded draw starvation and out-of-range access trapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int FB_DEPTH     = fb_pkg::FB_DEPTH
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      scan_req,
    input  logic [fb_pkg::ADDR_W-1:0] scan_addr,
    output logic                      scan_gnt,
    output logic [fb_pkg::PIX_W-1:0]  scan_rdata,
    output logic                      scan_rvalid,
    input  logic                      draw_req,
    input  logic                      draw_we,
    input  logic [fb_pkg::ADDR_W-1:0] draw_addr,
    input  logic [fb_pkg::PIX_W-1:0]  draw_wdata,
    output logic                      draw_gnt,
    output logic [fb_pkg::PIX_W-1:0]  draw_rdata,
    output logic                      draw_rvalid,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [fb_pkg::ADDR_W-1:0] mem_addr,
    output logic [fb_pkg::PIX_W-1:0]  mem_wdata,
    input  logic [fb_pkg::PIX_W-1:0]  mem_rdata,
    output logic                      addr_err
);

    import fb_pkg::*;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(FB_DEPTH);

    logic              w_starved;
    logic              w_scan_gnt;
    logic              w_draw_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [PIX_W-1:0]  w_sel_wdata;
    logic              w_oor;
    logic [PIX_W-1:0]  w_rdata;
    owner_t            w_owner_nxt;
    owner_t            r_owner;
    logic              r_oor;
    logic [PIX_W-1:0]  r_scan_hold;
    logic [PIX_W-1:0]  r_draw_hold;

    fb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .i_draw_req (draw_req),
        .i_draw_gnt (w_draw_gnt),
        .o_starved  (w_starved)
    );

    // Grants are gated by RESET_N so the memory strobes drop as soon as reset asserts.
    always_comb begin
        w_scan_gnt  = 1'b0;
        w_draw_gnt  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (RESET_N) begin
            if (draw_req && (w_starved || !scan_req)) begin
                w_draw_gnt  = 1'b1;
                w_sel_addr  = draw_addr;
                w_sel_wdata = draw_wdata;
            end else if (scan_req) begin
                w_scan_gnt  = 1'b1;
                w_sel_addr  = scan_addr;
            end
        end
        w_oor = (w_scan_gnt || w_draw_gnt) && ({1'b0, w_sel_addr} >= c_depth);
    end

    always_comb begin
        w_owner_nxt = IDLE;
        if (w_scan_gnt) begin
            w_owner_nxt = SCAN_RD;
        end else if (w_draw_gnt && !draw_we) begin
            w_owner_nxt = DRAW_RD;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_owner <= IDLE;
            r_oor   <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_oor   <= w_oor;
        end
    end

    // Trapped reads return zero instead of whatever the memory last produced.
    assign w_rdata = r_oor ? '0 : mem_rdata;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scan_hold <= '0;
            r_draw_hold <= '0;
        end else begin
            if (r_owner == SCAN_RD) r_scan_hold <= w_rdata;
            if (r_owner == DRAW_RD) r_draw_hold <= w_rdata;
        end
    end

    assign scan_gnt    = w_scan_gnt;
    assign draw_gnt    = w_draw_gnt;
    assign mem_en      = (w_scan_gnt || w_draw_gnt) && !w_oor;
    assign mem_we      = w_draw_gnt && draw_we && !w_oor;
    assign mem_addr    = w_sel_addr;
    assign mem_wdata   = w_sel_wdata;
    assign scan_rvalid = (r_owner == SCAN_RD);
    assign draw_rvalid = (r_owner == DRAW_RD);
    assign scan_rdata  = scan_rvalid ? w_rdata : r_scan_hold;
    assign draw_rdata  = draw_rvalid ? w_rdata : r_draw_hold;
    assign addr_err    = r_oor;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// Scoreboard bench for fb_arbiter: stimulus pushes expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_fb_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b1;
    logic        scan_req = 1'b0;
    logic [16:0] scan_addr = '0;
    logic        scan_gnt;
    logic [23:0] scan_rdata;
    logic        scan_rvalid;
    logic        draw_req = 1'b0;
    logic        draw_we  = 1'b0;
    logic [16:0] draw_addr = '0;
    logic [23:0] draw_wdata = '0;
    logic        draw_gnt;
    logic [23:0] draw_rdata;
    logic        draw_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    logic [23:0] scan_q[$];
    logic [23:0] draw_q[$];
    logic [23:0] mon_exp;
    logic        pend_err = 1'b0;
    logic        exp_err  = 1'b0;
    int          scan_run = 0;
    int          max_run  = 0;

    logic [23:0] mem [0:131071];

    fb_arbiter #(.STARVE_LIMIT(8), .FB_DEPTH(120000)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_gnt    (scan_gnt),
        .scan_rdata  (scan_rdata),
        .scan_rvalid (scan_rvalid),
        .draw_req    (draw_req),
        .draw_we     (draw_we),
        .draw_addr   (draw_addr),
        .draw_wdata  (draw_wdata),
        .draw_gnt    (draw_gnt),
        .draw_rdata  (draw_rdata),
        .draw_rvalid (draw_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .addr_err    (addr_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [23:0] pat(input int a);
        logic [31:0] v;
        v = a;
        return {7'h2D, v[16:0]};
    endfunction

    // Single-port memory model, one-cycle read latency.
    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = pat(i);
    end

    always @(posedge CLOCK_50) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    always @(posedge CLOCK_50) begin
        exp_err  = RESET_N ? pend_err : 1'b0;
        pend_err = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented read against the scoreboard.
    always @(negedge CLOCK_50) begin
        #2;
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        if (scan_rvalid) begin
            if (scan_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL scan_rvalid_unexpected actual=1 required=0 data=%0h", scan_rdata);
            end else begin
                mon_exp = scan_q.pop_front();
                chk("scan_rdata", {8'b0, scan_rdata}, {8'b0, mon_exp});
            end
            scan_run++;
            if (scan_run > max_run) max_run = scan_run;
        end else begin
            scan_run = 0;
        end
        if (draw_rvalid) begin
            if (draw_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL draw_rvalid_unexpected actual=1 required=0 data=%0h", draw_rdata);
            end else begin
                mon_exp = draw_q.pop_front();
                chk("draw_rdata", {8'b0, draw_rdata}, {8'b0, mon_exp});
            end
        end
    end

    task automatic cyc(input logic sr, input int sa, input logic dr, input logic dw,
                       input int da, input logic [23:0] dd);
        @(negedge CLOCK_50);
        scan_req   = sr;
        scan_addr  = sa[16:0];
        draw_req   = dr;
        draw_we    = dw;
        draw_addr  = da[16:0];
        draw_wdata = dd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 0, 24'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_scan_gnt"},    {31'b0, scan_gnt},    0);
        chk({tag, "_draw_gnt"},    {31'b0, draw_gnt},    0);
        chk({tag, "_scan_rvalid"}, {31'b0, scan_rvalid}, 0);
        chk({tag, "_draw_rvalid"}, {31'b0, draw_rvalid}, 0);
        chk({tag, "_mem_en"},      {31'b0, mem_en},      0);
        chk({tag, "_mem_we"},      {31'b0, mem_we},      0);
        chk({tag, "_addr_err"},    {31'b0, addr_err},    0);
        chk({tag, "_scan_rdata"},  {8'b0, scan_rdata},   0);
        chk({tag, "_draw_rdata"},  {8'b0, draw_rdata},   0);
        chk({tag, "_mem_addr"},    {15'b0, mem_addr},    0);
        chk({tag, "_mem_wdata"},   {8'b0, mem_wdata},    0);
        chk({tag, "_starve_cnt"},  32'(dut.u_starve_ctr.r_cnt), 0);
    endtask

    initial begin
        logic exp_d;

        // Reset with both requests asserted: grants and strobes must stay low.
        #1 RESET_N = 1'b0;
        scan_req = 1'b1; scan_addr = 17'd33;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'd44; draw_wdata = 24'h123456;
        repeat (2) @(negedge CLOCK_50);
        #1 chk_reset_outputs("rst");

        // Requests accepted on the first edge after release; scan read addr 5.
        @(negedge CLOCK_50);
        RESET_N  = 1'b1;
        scan_req = 1'b1; scan_addr = 17'd5;
        draw_req = 1'b0; draw_we = 1'b0; draw_addr = '0; draw_wdata = '0;
        #1;
        chk("s5_scan_gnt", {31'b0, scan_gnt}, 1);
        chk("s5_draw_gnt", {31'b0, draw_gnt}, 0);
        chk("s5_mem_en",   {31'b0, mem_en},   1);
        chk("s5_mem_we",   {31'b0, mem_we},   0);
        chk("s5_mem_addr", {15'b0, mem_addr}, 5);
        scan_q.push_back(pat(5));
        idle(2);

        // Contention: draw wins only after eight refusals.
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 20, 1'b1, 1'b0, 10, 24'h0);
            exp_d = (k == 9) || (k == 18);
            chk($sformatf("starve_draw_gnt_c%0d", k), {31'b0, draw_gnt}, {31'b0, exp_d});
            chk($sformatf("starve_scan_gnt_c%0d", k), {31'b0, scan_gnt}, {31'b0, !exp_d});
            if (exp_d) draw_q.push_back(pat(10));
            else       scan_q.push_back(pat(20));
        end
        idle(2);

        // Write the last valid pixel, then read it back.
        cyc(1'b0, 0, 1'b1, 1'b1, 119999, 24'hFF0000);
        chk("wr_draw_gnt",  {31'b0, draw_gnt},  1);
        chk("wr_mem_en",    {31'b0, mem_en},    1);
        chk("wr_mem_we",    {31'b0, mem_we},    1);
        chk("wr_mem_addr",  {15'b0, mem_addr},  119999);
        chk("wr_mem_wdata", {8'b0, mem_wdata},  32'hFF0000);
        cyc(1'b0, 0, 1'b1, 1'b0, 119999, 24'h0);
        chk("rd_draw_gnt",  {31'b0, draw_gnt},  1);
        chk("rd_mem_en",    {31'b0, mem_en},    1);
        chk("rd_mem_we",    {31'b0, mem_we},    0);
        draw_q.push_back(24'hFF0000);

        // First out-of-range address: trapped, zero data, error pulse.
        cyc(1'b0, 0, 1'b1, 1'b0, 120000, 24'h0);
        chk("oor_draw_gnt", {31'b0, draw_gnt}, 1);
        chk("oor_mem_en",   {31'b0, mem_en},   0);
        pend_err = 1'b1;
        draw_q.push_back(24'h000000);
        idle(2);

        // Reset between a scan grant and its rvalid discards the read.
        cyc(1'b1, 7, 1'b1, 1'b0, 3, 24'h0);
        chk("inf_scan_gnt", {31'b0, scan_gnt}, 1);
        #3 RESET_N = 1'b0;
        #1;
        chk("inf_gnt_in_rst", {31'b0, scan_gnt}, 0);
        chk("inf_mem_en_in_rst", {31'b0, mem_en}, 0);
        @(posedge CLOCK_50);
        #1 chk_reset_outputs("inf");
        @(negedge CLOCK_50);
        RESET_N  = 1'b1;
        scan_req = 1'b0;
        draw_req = 1'b0;
        idle(3);

        // Back-to-back scan reads across one line.
        max_run = 0;
        for (int a = 0; a < 200; a++) begin
            cyc(1'b1, a, 1'b0, 1'b0, 0, 24'h0);
            chk($sformatf("burst_gnt_%0d", a), {31'b0, scan_gnt}, 1);
            scan_q.push_back(pat(a));
        end
        idle(3);
        chk("burst_rvalid_run", 32'(max_run), 200);

        idle(2);
        chk("scan_q_empty", 32'(scan_q.size()), 0);
        chk("draw_q_empty", 32'(draw_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
